// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage -- WISC instruction fetch: PC, imem handshake, IF/ID register with one-entry skid buffer.
// Revision 1.0
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_inst,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] pc;
  logic [15:0] redir_pc;
  logic [15:0] buf_inst;
  logic [15:0] buf_pc2;
  logic        buf_valid;
  logic        halt_pending;
  logic        halt_ok;
  logic        drain_to_halt;
  logic [15:0] pc_plus2;

  assign halt_ok       = halt & if_valid & ~stall;
  assign pc_plus2      = pc + 16'd2;
  // A redirect arriving during the drain cancels a pending halt.
  assign drain_to_halt = halt_pending & ~redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (redirect)                 state_nxt = imem_ready ? S_FETCH : S_DRAIN;
        else if (halt_ok)             state_nxt = imem_ready ? S_HALTED : S_DRAIN;
        else if (imem_ready && stall) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (redirect)     state_nxt = S_FETCH;
        else if (halt_ok) state_nxt = S_HALTED;
        else if (!stall)  state_nxt = S_FETCH;
      end
      S_DRAIN: begin
        if (imem_ready) state_nxt = drain_to_halt ? S_HALTED : S_FETCH;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == S_FETCH) || (state == S_DRAIN);
    imem_addr = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      redir_pc     <= 16'h0000;
      halt_pending <= 1'b0;
      buf_inst     <= 16'h0000;
      buf_pc2      <= 16'h0000;
      buf_valid    <= 1'b0;
      if_inst      <= NOP_INST;
      if_pc_plus2  <= 16'h0000;
      if_valid     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (redirect) begin
            if_valid  <= 1'b0;
            if_inst   <= NOP_INST;
            buf_valid <= 1'b0;
            if (imem_ready) begin
              pc <= redirect_pc;
            end else begin
              redir_pc     <= redirect_pc;
              halt_pending <= 1'b0;
            end
          end else if (halt_ok) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            if (!imem_ready) halt_pending <= 1'b1;
          end else if (imem_ready) begin
            pc <= pc_plus2;
            if (stall) begin
              buf_inst  <= imem_rdata;
              buf_pc2   <= pc_plus2;
              buf_valid <= 1'b1;
            end else begin
              if_inst     <= imem_rdata;
              if_pc_plus2 <= pc_plus2;
              if_valid    <= 1'b1;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            buf_valid <= 1'b0;
            if_valid  <= 1'b0;
            if_inst   <= NOP_INST;
            pc        <= redirect_pc;
          end else if (halt_ok) begin
            buf_valid <= 1'b0;
            if_valid  <= 1'b0;
            if_inst   <= NOP_INST;
          end else if (!stall) begin
            if_inst     <= buf_valid ? buf_inst : NOP_INST;
            if_pc_plus2 <= buf_pc2;
            if_valid    <= buf_valid;
            buf_valid   <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (redirect) begin
            redir_pc     <= redirect_pc;
            halt_pending <= 1'b0;
          end
          if (imem_ready && !drain_to_halt) pc <= redirect ? redirect_pc : redir_pc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
